// File: rtl/multi_sync_debounce.sv
// Multi-channel input conditioner: per-channel synchroniser chain followed by an
// independent stability counter, with registered rise/fall strobes and a change flag.
`timescale 1ns / 1ps

module multi_sync_debounce #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned DEBOUNCE_PRD = 50,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic        RESET_VAL    = 1'b0
) (
    input  logic                dest_clk_i,
    input  logic                dest_rst_n_i,
    input  logic [CHANNELS-1:0] raw_sig_i,
    input  logic                enable_i,
    output logic [CHANNELS-1:0] sync_sig_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                any_change_o
);

    localparam int unsigned     CntW    = $clog2(DEBOUNCE_PRD + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_PRD - 1);

    logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CHANNELS-1:0]                  s;
    logic [CHANNELS-1:0][CntW-1:0]        cnt_q;
    logic [CHANNELS-1:0][CntW-1:0]        cnt_d;
    logic [CHANNELS-1:0]                  level_d;
    logic [CHANNELS-1:0]                  rise_d;
    logic [CHANNELS-1:0]                  fall_d;
    logic                                 any_d;

    // Plain shift chain; nothing may sit between stages.
    always_ff @(posedge dest_clk_i or negedge dest_rst_n_i) begin
        if (!dest_rst_n_i) begin
            sync_q <= {CHANNELS{{SYNC_STAGES{RESET_VAL}}}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_sig_i[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        level_d = sync_sig_o;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!enable_i || (s[i] == sync_sig_o[i])) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        any_d = |{rise_d, fall_d};
    end

    always_ff @(posedge dest_clk_i or negedge dest_rst_n_i) begin
        if (!dest_rst_n_i) begin
            cnt_q        <= '0;
            sync_sig_o   <= {CHANNELS{RESET_VAL}};
            rise_o       <= '0;
            fall_o       <= '0;
            any_change_o <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sync_sig_o   <= level_d;
            rise_o       <= rise_d;
            fall_o       <= fall_d;
            any_change_o <= any_d;
        end
    end

endmodule
